dec_nto2n_seq: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder, the next generation of our fixed 3-to-8 decoders built from 2-to-4 cells. Adds a clocked output register, an enable, and a self-timed scan mode in which a walking one steps through all outputs with a programmable dwell. Used for row/digit strobing and chip-select generation wherever a plain combinational decoder would need external counters.

---
 rtl/dec_nto2n_seq.sv | 116 +++++++++++
 tb/tb_dec_nto2n_seq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dec_nto2n_seq.sv
// dec_nto2n_seq: registered N-to-2^N one-hot decoder with enable and optional
// self-timed scan mode (walking one with a programmable dwell).
//
// Build option: define DEC_SCAN_EN to compile in the SCAN state, the dwell
// counter and the wrap pulse. Without it, mode/load are ignored, the block
// decodes sel whenever en=1, and wrap is tied low. The port list is the same
// in both builds.
//
// Parameters:
//   N      select width, output width is 2^N (1..8)
//   HOLD   scan dwell in cycles per output (>=1)
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   en     enable; 0 forces idle
//   mode   0 = direct decode of sel, 1 = scan
//   sel    direct select / scan start and reload index
//   load   in scan, reload the scan index from sel
//   o      registered one-hot output, zero when idle
//   idx    index of the asserted output bit (held while idle)
//   active high whenever o is non-zero
//   wrap   one-cycle pulse when the scan index wraps 2^N-1 -> 0
module dec_nto2n_seq #(
    parameter int N    = 3,
    parameter int HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      sel,
    input  logic              load,
    output logic [(1<<N)-1:0] o,
    output logic [N-1:0]      idx,
    output logic              active,
    output logic              wrap
);
    localparam int W = 1 << N;

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [W-1:0]   o_q, o_d;

`ifdef DEC_SCAN_EN
    localparam int DW = (HOLD > 1) ? $clog2(HOLD) : 1;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic           wrap_q, wrap_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = '0;
        wrap_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else if (mode) begin
            state_d = SCAN;
            // Entry and load both restart the walk at sel; load beats the dwell step.
            if (state_q != SCAN || load) begin
                idx_d = sel;
            end else if (dwell_q == DW'(HOLD - 1)) begin
                idx_d  = idx_q + 1'b1;
                wrap_d = &idx_q;
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end else begin
            state_d = DIRECT;
            idx_d   = sel;
        end
        o_d = (state_d == IDLE) ? '0 : {{(W-1){1'b0}}, 1'b1} << idx_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            wrap_q  <= wrap_d;
        end
    end

    assign wrap = wrap_q;
`else
    logic unused_scan;

    assign unused_scan = &{1'b0, mode, load, HOLD[0]};

    always_comb begin
        state_d = en ? DIRECT : IDLE;
        idx_d   = en ? sel : idx_q;
        o_d     = en ? {{(W-1){1'b0}}, 1'b1} << sel : '0;
    end

    assign wrap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            o_q     <= o_d;
        end
    end

    assign o      = o_q;
    assign idx    = idx_q;
    assign active = (state_q != IDLE);
endmodule

// File: tb/tb_dec_nto2n_seq.sv
// tb_dec_nto2n_seq: randomized self-checking bench for dec_nto2n_seq (N=3),
// two instances with HOLD=2 and HOLD=1 sharing one stimulus stream.
module tb_dec_nto2n_seq;
`ifdef DEC_SCAN_EN
    localparam bit SCAN_ON = 1'b1;
`else
    localparam bit SCAN_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, mode = 1'b0, load = 1'b0;
    logic [2:0] sel = '0;
    logic [7:0] o2, o1;
    logic [2:0] i2, i1;
    logic       a2, a1, w2, w1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dec_nto2n_seq #(.N(3), .HOLD(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
        .o(o2), .idx(i2), .active(a2), .wrap(w2)
    );

    dec_nto2n_seq #(.N(3), .HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
        .o(o1), .idx(i1), .active(a1), .wrap(w1)
    );

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a scan is described by its start index and the number
    // of cycles elapsed since it started; the index is start + t/HOLD.
    int hv[2] = '{2, 1};
    int ms[2];      // 0 idle, 1 direct, 2 scan
    int mstart[2];
    int mt[2];
    int midx[2];
    int mwrap[2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            mwrap[k] = 0;
            if (!rst_n) begin
                ms[k] = 0; midx[k] = 0; mt[k] = 0; mstart[k] = 0;
            end else if (!en) begin
                ms[k] = 0;
            end else if (!SCAN_ON || !mode) begin
                ms[k] = 1; midx[k] = sel;
            end else if (ms[k] != 2 || load) begin
                ms[k] = 2; mstart[k] = sel; mt[k] = 0; midx[k] = sel;
            end else begin
                mt[k]++;
                midx[k]  = (mstart[k] + mt[k] / hv[k]) % 8;
                mwrap[k] = (mt[k] % hv[k] == 0 && midx[k] == 0) ? 1 : 0;
            end
        end
        #1;
        if (rst_n) begin
            chk("m2_o", o2, ms[0] != 0 ? (1 << midx[0]) : 0);
            chk("m2_idx", i2, midx[0]);
            chk("m2_active", a2, ms[0] != 0 ? 1 : 0);
            chk("m2_wrap", w2, mwrap[0]);
            chk("m1_o", o1, ms[1] != 0 ? (1 << midx[1]) : 0);
            chk("m1_idx", i1, midx[1]);
            chk("m1_active", a1, ms[1] != 0 ? 1 : 0);
            chk("m1_wrap", w1, mwrap[1]);
        end
    end

    task automatic cyc(input logic e, input logic m, input logic [2:0] s, input logic l);
        @(negedge clk);
        en = e; mode = m; sel = s; load = l;
        @(posedge clk);
        #2;
    endtask

    task automatic areset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_o", o2 | o1, 0);
        chk("areset_idx", i2 | i1, 0);
        chk("areset_active", a2 | a1, 0);
        chk("areset_wrap", w2 | w1, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        #3;
        chk("reset_o", o2, 0);
        chk("reset_active", a2, 0);
        @(negedge clk);
        rst_n = 1'b1;

        cyc(1, 0, 5, 0);
        chk("direct5_o", o2, 8'h20);
        chk("direct5_idx", i2, 5);
        chk("direct5_active", a2, 1);
        for (int s = 0; s < 8; s++) begin
            cyc(1, 0, 3'(s), 1);
            chk("sweep_o", o1, 1 << s);
        end
        cyc(0, 0, 3, 0);
        chk("idle_o", o2, 0);
        chk("idle_idx_hold", i2, 7);
        cyc(1, 0, 4, 0);
        areset();

`ifdef DEC_SCAN_EN
        cyc(0, 0, 0, 0);
        cyc(1, 1, 6, 0); chk("scan_t0", o2, 8'h40);
        cyc(1, 1, 6, 0); chk("scan_t1", o2, 8'h40);
        cyc(1, 1, 6, 0); chk("scan_t2", o2, 8'h80);
        cyc(1, 1, 6, 0); chk("scan_t3", o2, 8'h80); chk("scan_t3_wrap", w2, 0);
        cyc(1, 1, 6, 0); chk("scan_t4", o2, 8'h01); chk("scan_t4_wrap", w2, 1);
        cyc(1, 1, 6, 0); chk("scan_t5", o2, 8'h01); chk("scan_t5_wrap", w2, 0);
        for (int k = 0; k < 5; k++) cyc(1, 1, 6, 0);
        chk("scan_t10", o2, 8'h08);
        cyc(1, 1, 6, 0); chk("scan_t11", o2, 8'h08);
        cyc(1, 1, 0, 1); chk("load_o0", o2, 8'h01); chk("load_wrap0", w2, 0);
        cyc(1, 1, 0, 0); chk("load_o1", o2, 8'h01); chk("load_wrap1", w2, 0);
        cyc(1, 1, 0, 0); chk("load_o2", o2, 8'h02);
        cyc(1, 0, 2, 0); chk("switch_direct2", o2, 8'h04); chk("switch_direct1", o1, 8'h04);
        cyc(1, 1, 5, 0); chk("rescan1_t0", o1, 8'h20);
        cyc(1, 1, 5, 0); chk("rescan1_t1", o1, 8'h40); chk("rescan2_t1", o2, 8'h20);
        cyc(1, 1, 1, 0);
        areset();
        cyc(1, 1, 1, 0); chk("post_reset_scan", o2, 8'h02);
        cyc(0, 0, 0, 0);
        cyc(1, 1, 7, 0);
        n = 0;
        while (!w2 && n < 40) begin cyc(1, 1, 7, 0); n++; end
        chk("first_wrap_delay", n, 2);
        n = 0;
        do begin cyc(1, 1, 7, 0); n++; end while (!w2 && n < 40);
        chk("wrap_period", n, 16);
`else
        for (int k = 0; k < 20; k++) begin
            cyc(1, 1, 4, k % 3 == 0);
            chk("noscan_o", o2, 8'h10);
            chk("noscan_wrap", w2 | w1, 0);
        end
`endif

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) areset();
            else cyc($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
                     3'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
